// File: rtl/sc_run_ctrl.sv
// Run sequencer for the stochastic-number datapath: seeds the generators, clears the
// ones-counters, advances the generators for LENGTH cycles and gates the counters behind the pipe.
module sc_run_ctrl #(
    parameter int unsigned LEN_W    = 32,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             ACK,
    input  logic [LEN_W-1:0] LENGTH,
    output logic             SNG_LOAD,
    output logic             SNG_EN,
    output logic             CNT_CLR,
    output logic             CNT_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [LEN_W-1:0] ELAPSED
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned DLY_W = (PIPE_LAT > 0) ? PIPE_LAT : 1;
    localparam int unsigned DRN_W = ($clog2(PIPE_LAT + 1) > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

    logic [2:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] elapsed_q;
    logic [DRN_W-1:0] drain_cnt;
    logic [DLY_W-1:0] dly;
    logic             sng_en;
    logic             cnt_en;
    logic             abort_hit;
    logic             start_ok;

    assign abort_hit = ABORT && (state != S_IDLE);
    assign start_ok  = START && !ABORT && ((state == S_IDLE) || (state == S_DONE));

    assign sng_en = (state == S_RUN);
    // With no pipeline the counters follow the generator enable directly.
    assign cnt_en = (PIPE_LAT == 0) ? sng_en : dly[DLY_W-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            len_q     <= '0;
            remaining <= '0;
            elapsed_q <= '0;
            drain_cnt <= '0;
            dly       <= '0;
        end else if (abort_hit) begin
            // Abort flushes the in-flight enables but keeps ELAPSED for the host.
            state <= S_IDLE;
            dly   <= '0;
        end else begin
            for (int unsigned i = DLY_W - 1; i > 0; i--) begin
                dly[i] <= dly[i-1];
            end
            dly[0] <= sng_en;

            if (cnt_en) begin
                elapsed_q <= elapsed_q + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state <= S_LOAD;
                        len_q <= LENGTH;
                    end
                end
                S_LOAD: begin
                    elapsed_q <= '0;
                    remaining <= len_q;
                    drain_cnt <= DRN_INIT;
                    if (len_q != '0) begin
                        state <= S_RUN;
                    end else if (PIPE_LAT > 0) begin
                        state <= S_DRAIN;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_RUN: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state <= (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (start_ok) begin
                        state <= S_LOAD;
                        len_q <= LENGTH;
                    end else if (ACK) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign SNG_LOAD = (state == S_LOAD);
    assign CNT_CLR  = (state == S_LOAD);
    assign SNG_EN   = sng_en;
    assign CNT_EN   = cnt_en;
    assign BUSY     = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign DONE     = (state == S_DONE);
    assign ELAPSED  = elapsed_q;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// Bench for sc_run_ctrl: two instances (pipe latency 2 and 0) share stimulus and are
// checked every cycle against a run-timeline model, plus literal checks from the test plan.
module tb_sc_run_ctrl;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] length = '0;

    logic [1:0]  sng_load, sng_en, cnt_clr, cnt_en, busy, done;
    logic [31:0] elapsed [2];

    int ntests = 0;
    int nfail  = 0;

    longint cyc = 0;
    bit     armed = 1'b0;

    // Model state: one run timeline per instance.
    bit     act [2];
    longint tl  [2];
    longint ml  [2];
    longint frz [2];
    longint pl  [2];

    always #5 CLK = ~CLK;

    sc_run_ctrl #(.LEN_W(32), .PIPE_LAT(2)) dut0 (
        .CLK(CLK), .RST(rst), .START(start), .ABORT(abort), .ACK(ack), .LENGTH(length),
        .SNG_LOAD(sng_load[0]), .SNG_EN(sng_en[0]), .CNT_CLR(cnt_clr[0]), .CNT_EN(cnt_en[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ELAPSED(elapsed[0])
    );

    sc_run_ctrl #(.LEN_W(32), .PIPE_LAT(0)) dut1 (
        .CLK(CLK), .RST(rst), .START(start), .ABORT(abort), .ACK(ack), .LENGTH(length),
        .SNG_LOAD(sng_load[1]), .SNG_EN(sng_en[1]), .CNT_CLR(cnt_clr[1]), .CNT_EN(cnt_en[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ELAPSED(elapsed[1])
    );

    task automatic chk(input string nm, input int k, input longint act_v, input longint exp_v);
        ntests++;
        if (act_v != exp_v) begin
            nfail++;
            $display("FAIL %s[dut%0d] cycle %0d: got %0d, expected %0d", nm, k, cyc, act_v, exp_v);
        end
    endtask

    // Expected outputs in cycle c, relative to the LOAD cycle of the current run.
    task automatic exp_vals(input int k, input longint c,
                            output bit e_ld, output bit e_en, output bit e_cen,
                            output bit e_busy, output bit e_done, output longint e_el);
        longint rel, l, p, n;
        if (!act[k]) begin
            e_ld = 0; e_en = 0; e_cen = 0; e_busy = 0; e_done = 0; e_el = frz[k];
        end else begin
            rel = c - tl[k];
            l = ml[k];
            p = pl[k];
            e_ld   = (rel == 0);
            e_en   = (rel >= 1) && (rel <= l);
            e_cen  = (rel >= 1 + p) && (rel <= l + p);
            e_done = (rel >= l + p + 1);
            e_busy = !e_done;
            n = rel - 1 - p;
            if (n < 0) n = 0;
            if (n > l) n = l;
            e_el = (rel == 0) ? frz[k] : n;
        end
    endtask

    initial begin
        pl[0] = 2; pl[1] = 0;
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; tl[k] = 0; ml[k] = 0; frz[k] = 0;
        end
    end

    always @(posedge CLK) begin
        bit ld, en, cen, bz, dn;
        longint el;
        for (int k = 0; k < 2; k++) begin
            exp_vals(k, cyc, ld, en, cen, bz, dn, el);
            if (rst) begin
                act[k] = 0; frz[k] = 0;
            end else if (act[k] && abort) begin
                act[k] = 0; frz[k] = el;
            end else if ((!act[k] || dn) && start && !abort) begin
                act[k] = 1; tl[k] = cyc + 1; ml[k] = longint'(length); frz[k] = el;
            end else if (act[k] && dn && ack) begin
                act[k] = 0; frz[k] = el;
            end
        end
        if (rst) armed = 1'b1;
        cyc++;
    end

    always @(negedge CLK) begin
        bit ld, en, cen, bz, dn;
        longint el;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                exp_vals(k, cyc, ld, en, cen, bz, dn, el);
                chk("m_sng_load", k, longint'(sng_load[k]), longint'(ld));
                chk("m_cnt_clr",  k, longint'(cnt_clr[k]),  longint'(ld));
                chk("m_sng_en",   k, longint'(sng_en[k]),   longint'(en));
                chk("m_cnt_en",   k, longint'(cnt_en[k]),   longint'(cen));
                chk("m_busy",     k, longint'(busy[k]),     longint'(bz));
                chk("m_done",     k, longint'(done[k]),     longint'(dn));
                chk("m_elapsed",  k, longint'(elapsed[k]),  el);
            end
        end
    end

    task automatic at(input longint n);
        while (cyc < n) @(negedge CLK);
    endtask

    initial begin
        longint b;
        repeat (3) @(negedge CLK);
        chk("rst_done", 0, longint'(done[0]), 0);
        chk("rst_elapsed", 1, longint'(elapsed[1]), 0);
        rst = 1'b0;

        // Nominal run, L=5.
        b = cyc + 2; at(b);
        start = 1; length = 5;
        at(b + 1); start = 0;
        chk("a_load", 0, longint'(sng_load[0]), 1);
        chk("a_clr", 0, longint'(cnt_clr[0]), 1);
        at(b + 2);
        chk("a_load_off", 0, longint'(sng_load[0]), 0);
        chk("a_en_first", 0, longint'(sng_en[0]), 1);
        chk("a_cen_early", 0, longint'(cnt_en[0]), 0);
        at(b + 4); chk("a_cen_first", 0, longint'(cnt_en[0]), 1);
        at(b + 6); chk("a_en_last", 0, longint'(sng_en[0]), 1);
        at(b + 7); chk("a_en_off", 0, longint'(sng_en[0]), 0);
        at(b + 8); chk("a_cen_last", 0, longint'(cnt_en[0]), 1);
        chk("a_done_early", 0, longint'(done[0]), 0);
        at(b + 9);
        chk("a_done", 0, longint'(done[0]), 1);
        chk("a_elapsed", 0, longint'(elapsed[0]), 5);
        chk("a_cen_off", 0, longint'(cnt_en[0]), 0);
        at(b + 12); ack = 1;
        at(b + 13); ack = 0;
        chk("a_ack_done", 0, longint'(done[0]), 0);
        chk("a_ack_busy", 0, longint'(busy[0]), 0);

        // Zero-length run.
        b = cyc + 2; at(b);
        start = 1; length = 0;
        at(b + 1); start = 0;
        at(b + 2);
        chk("b_drain_busy", 0, longint'(busy[0]), 1);
        chk("b_drain_en", 0, longint'(sng_en[0]), 0);
        chk("b_p0_done", 1, longint'(done[1]), 1);
        at(b + 3); chk("b_drain2", 0, longint'(busy[0]), 1);
        at(b + 4);
        chk("b_done", 0, longint'(done[0]), 1);
        chk("b_elapsed", 0, longint'(elapsed[0]), 0);
        at(b + 6); ack = 1;
        at(b + 7); ack = 0;

        // L=3 on the zero-latency instance.
        b = cyc + 2; at(b);
        start = 1; length = 3;
        at(b + 1); start = 0;
        chk("c_cen_load", 1, longint'(cnt_en[1]), 0);
        at(b + 2);
        chk("c_en2", 1, longint'(sng_en[1]), 1);
        chk("c_cen2", 1, longint'(cnt_en[1]), 1);
        at(b + 4); chk("c_cen4", 1, longint'(cnt_en[1]), 1);
        at(b + 5);
        chk("c_done", 1, longint'(done[1]), 1);
        chk("c_elapsed", 1, longint'(elapsed[1]), 3);
        at(b + 9); ack = 1;
        at(b + 10); ack = 0;

        // Abort in cycle 4 of an L=10 run.
        b = cyc + 2; at(b);
        start = 1; length = 10;
        at(b + 1); start = 0;
        at(b + 4); abort = 1;
        at(b + 5); abort = 0;
        chk("d_en", 1, longint'(sng_en[1]), 0);
        chk("d_cen", 1, longint'(cnt_en[1]), 0);
        chk("d_busy", 1, longint'(busy[1]), 0);
        chk("d_done", 1, longint'(done[1]), 0);
        chk("d_elapsed", 1, longint'(elapsed[1]), 2);
        chk("d_elapsed_p2", 0, longint'(elapsed[0]), 0);
        at(b + 8); chk("d_hold", 1, longint'(elapsed[1]), 2);

        // Ignored START/LENGTH during a run, then back-to-back run from DONE.
        b = cyc + 2; at(b);
        start = 1; length = 6;
        at(b + 1); start = 0;
        at(b + 3); start = 1; length = 99;
        at(b + 4); start = 0;
        at(b + 5); start = 1;
        at(b + 6); start = 0;
        at(b + 10);
        chk("e_done", 0, longint'(done[0]), 1);
        chk("e_elapsed0", 0, longint'(elapsed[0]), 6);
        chk("e_elapsed1", 1, longint'(elapsed[1]), 6);
        at(b + 11); start = 1; length = 4;
        at(b + 12); start = 0;
        chk("e_b2b_load", 0, longint'(sng_load[0]), 1);
        chk("e_b2b_clr", 1, longint'(cnt_clr[1]), 1);
        at(b + 13); chk("e_b2b_cleared", 0, longint'(elapsed[0]), 0);
        at(b + 19);
        chk("e_b2b_done", 0, longint'(done[0]), 1);
        chk("e_b2b_elapsed", 0, longint'(elapsed[0]), 4);
        at(b + 21); ack = 1;
        at(b + 22); ack = 0;

        // START together with ABORT in IDLE.
        b = cyc + 2; at(b);
        start = 1; abort = 1; length = 3;
        at(b + 1); start = 0; abort = 0;
        chk("f_busy", 0, longint'(busy[0]), 0);
        chk("f_load", 1, longint'(sng_load[1]), 0);

        // Reset mid-run.
        b = cyc + 2; at(b);
        start = 1; length = 20;
        at(b + 1); start = 0;
        at(b + 5);
        chk("g_pre_elapsed", 1, longint'(elapsed[1]), 3);
        rst = 1;
        at(b + 6); rst = 0;
        chk("g_en", 1, longint'(sng_en[1]), 0);
        chk("g_busy", 0, longint'(busy[0]), 0);
        chk("g_elapsed", 1, longint'(elapsed[1]), 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            start = ($urandom % 8) == 0;
            abort = ($urandom % 40) == 0;
            ack   = ($urandom % 5) == 0;
            rst   = ($urandom % 500) == 0;
            if (($urandom % 4) == 0) length = $urandom_range(0, 12);
        end
        @(negedge CLK);
        start = 0; abort = 0; ack = 0; rst = 0;
        repeat (30) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/sc_run_ctrl.md
Name: sc_run_ctrl

Overview:
Run sequencer for the stochastic-number datapath. On START it loads the SN generator seeds and clears the ones-counters through their data write port. It then advances the generators for exactly LENGTH cycles and asserts counter enable for LENGTH cycles, delayed by the generator pipeline latency. When the run is finished it raises DONE so the host can read the counters.

Parameters:
LEN_W, 32, width of LENGTH and ELAPSED
PIPE_LAT, 2, cycles from SNG_EN high to the matching SN bit at the counter input; 0 is legal

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
START  in  1  run request, sampled in IDLE or DONE
ABORT  in  1  terminate the current run
ACK  in  1  host acknowledge, clears DONE
LENGTH  in  LEN_W  number of SN bits to count; captured when START is accepted
SNG_LOAD  out  1  one-cycle seed load strobe to the generators
SNG_EN  out  1  advance the generators
CNT_CLR  out  1  drives the counters' data write enable, with write data tied to 0
CNT_EN  out  1  counter enable
BUSY  out  1  high in LOAD, RUN and DRAIN
DONE  out  1  high in DONE state
ELAPSED  out  LEN_W  number of CNT_EN cycles in the current or last run

Behaviour:
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Reset values: state IDLE; all strobes/enables 0; BUSY 0; DONE 0; ELAPSED 0; delay line 0; captured length 0.
- IDLE -> LOAD when START=1 and ABORT=0.
- DONE -> LOAD when START=1 and ABORT=0. START has priority over ACK.
- DONE -> IDLE when ACK=1 and START=0.
- LOAD (1 cycle):
  - SNG_LOAD=1, CNT_CLR=1, ELAPSED<=0, remaining-count register <= captured length.
  - Go to RUN if length>0.
  - If length=0, go to DRAIN when PIPE_LAT>0, otherwise go to DONE.
- RUN:
  - SNG_EN=1; remaining decrements each cycle.
  - Go to DRAIN on the cycle where remaining=1; if PIPE_LAT=0, go to DONE instead.
  - SNG_EN is high for exactly LENGTH cycles.
- DRAIN: SNG_EN=0 for exactly PIPE_LAT cycles, then go to DONE.
- CNT_EN is SNG_EN delayed by PIPE_LAT cycles through a shift register. With PIPE_LAT=0, CNT_EN equals the SNG_EN state decode in the same cycle.
- ELAPSED increments on each cycle with CNT_EN=1. It ends equal to LENGTH and never wraps, because LENGTH is at most 2^LEN_W-1.
- Timing: START accepted at edge 0, length L>0, latency P.
  - LOAD in cycle 1.
  - SNG_EN high in cycles 2..L+1.
  - CNT_EN high in cycles 2+P..L+1+P.
  - DONE first high in cycle L+2+P.
- Inputs ignored while BUSY: START, ACK and changes on LENGTH.
- ABORT in LOAD, RUN, DRAIN or DONE:
  - Next state IDLE; the delay line is cleared the same edge.
  - SNG_EN, CNT_EN, BUSY and DONE are all 0 on the following cycle.
  - ELAPSED holds its value.
- ABORT has priority over START when both are high in the same cycle.
- ABORT in IDLE has no effect.
- RST overrides everything, including mid-run; the reset values apply on the next cycle.

Test Plan:
- Nominal run, PIPE_LAT=2, LENGTH=5, START pulse at cycle 0 ->
  - SNG_LOAD and CNT_CLR high in cycle 1 only;
  - SNG_EN high cycles 2-6; CNT_EN high cycles 4-8;
  - DONE high from cycle 9; ELAPSED=5;
  - ACK in cycle 12 -> IDLE and DONE=0 in cycle 13.
- LENGTH=0 with PIPE_LAT=2 -> LOAD, then DRAIN cycles 2-3, then DONE in cycle 4; SNG_EN and CNT_EN never high; ELAPSED=0.
- PIPE_LAT=0, LENGTH=3 -> SNG_EN and CNT_EN both high in cycles 2-4; DONE in cycle 5.
- ABORT in cycle 4 of a LENGTH=10 run ->
  - cycle 5: SNG_EN=0, CNT_EN=0, BUSY=0, DONE=0;
  - ELAPSED equals the count reached (2 with PIPE_LAT=0), then holds.
- START pulses during RUN and LENGTH changed to 99 mid-run -> ignored; run completes with ELAPSED equal to the original LENGTH.
- Back-to-back runs: START in DONE with LENGTH=4 -> LOAD next cycle, counters cleared, new run of 4.
- Simultaneous START+ABORT in IDLE -> stays IDLE.
- RST asserted mid-RUN -> all outputs 0 and ELAPSED=0 in the next cycle.
